// File: rtl/fault_map_loader.sv
// -----------------------------------------------------------------------------
// fault_map_loader
//
// Reads a per-PE fault map for an S x S systolic array out of eNVM, one row
// per read. Each row is a bit vector in which bit c marks PE(row, c) as faulty.
// The rows are assembled into a flat bypass vector. The block also keeps a
// running count of faulty PEs.
//
// Build option:
//   FAULT_MAP_TIMEOUT_EN - when defined, a read that gets no response within
//                          TIMEOUT_CYCLES aborts the load and sets a sticky
//                          load_err. When undefined, the loader waits forever
//                          for read data and load_err is tied low.
//
// Ports:
//   clk            in   rising-edge clock
//   rst_n          in   asynchronous active-low reset
//   load_start     in   one-cycle request to start a load (accepted in idle only)
//   envm_rd_en     out  one-cycle read strobe per row
//   envm_rd_addr   out  row pointer (held in every state)
//   envm_rd_valid  in   read data valid (sampled only while waiting for data)
//   envm_rd_data   in   row fault bits
//   pe_bypass      out  bit r*S+c = PE(r,c) bypassed
//   col_fault_any  out  per-column OR of pe_bypass over all rows
//   fault_count    out  total faulty PEs in the loaded map
//   busy           out  load in progress
//   done           out  one-cycle completion pulse
//   map_valid      out  pe_bypass holds a complete map
//   load_err       out  sticky timeout error
// -----------------------------------------------------------------------------
module fault_map_loader #(
    parameter int SYSTOLIC_SIZE  = 8,
    parameter int ADDR_WIDTH     = $clog2(SYSTOLIC_SIZE),
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                                            clk,
    input  logic                                            rst_n,
    input  logic                                            load_start,
    output logic                                            envm_rd_en,
    output logic [ADDR_WIDTH-1:0]                           envm_rd_addr,
    input  logic                                            envm_rd_valid,
    input  logic [SYSTOLIC_SIZE-1:0]                        envm_rd_data,
    output logic [SYSTOLIC_SIZE*SYSTOLIC_SIZE-1:0]          pe_bypass,
    output logic [SYSTOLIC_SIZE-1:0]                        col_fault_any,
    output logic [$clog2(SYSTOLIC_SIZE*SYSTOLIC_SIZE+1)-1:0] fault_count,
    output logic                                            busy,
    output logic                                            done,
    output logic                                            map_valid,
    output logic                                            load_err
);

    localparam int S  = SYSTOLIC_SIZE;
    localparam int CW = $clog2(S*S+1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(S-1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_ptr;
    logic                    r_rd_en;
    logic [S*S-1:0]          r_bypass;
    logic [CW-1:0]           r_count;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_map_valid;
    logic [S-1:0]            w_col_any;

`ifdef FAULT_MAP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES+1);
    localparam logic [TW-1:0] WAIT_LIMIT = TW'(TIMEOUT_CYCLES-1);
    logic [TW-1:0]           r_wait_cnt;
    logic                    r_load_err;
`else
    // The timeout value only has meaning when the timeout logic is built in.
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
    end
`endif

    // Number of set bits in one row; a full row contributes at most S.
    function automatic logic [CW-1:0] popcount(input logic [S-1:0] v);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < S; i++) begin
            n = n + CW'(v[i]);
        end
        return n;
    endfunction

    // Load sequencer: row pointer, read strobe, map assembly and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= {ADDR_WIDTH{1'b0}};
            r_rd_en     <= 1'b0;
            r_bypass    <= {(S*S){1'b0}};
            r_count     <= {CW{1'b0}};
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_map_valid <= 1'b0;
`ifdef FAULT_MAP_TIMEOUT_EN
            r_wait_cnt  <= {TW{1'b0}};
            r_load_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (load_start) begin
                        r_bypass    <= {(S*S){1'b0}};
                        r_count     <= {CW{1'b0}};
                        r_map_valid <= 1'b0;
                        r_ptr       <= {ADDR_WIDTH{1'b0}};
                        r_rd_en     <= 1'b1;
                        r_busy      <= 1'b1;
                        r_state     <= ST_REQ;
`ifdef FAULT_MAP_TIMEOUT_EN
                        r_load_err  <= 1'b0;
`endif
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    // The strobe was raised on entry, so it lasts exactly this cycle.
                    r_rd_en <= 1'b0;
                    r_state <= ST_WAIT;
`ifdef FAULT_MAP_TIMEOUT_EN
                    r_wait_cnt <= {TW{1'b0}};
`endif
                end
                ST_WAIT: begin
                    if (envm_rd_valid) begin
                        for (int r = 0; r < S; r++) begin
                            if (r_ptr == ADDR_WIDTH'(r)) begin
                                r_bypass[r*S +: S] <= envm_rd_data;
                            end
                        end
                        // Count is cleared per load and gains at most S per row,
                        // so it tops out at S*S without wrapping.
                        r_count <= r_count + popcount(envm_rd_data);
                        if (r_ptr == LAST_ROW) begin
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_map_valid <= 1'b1;
                            r_state     <= ST_DONE;
                        end else begin
                            r_ptr   <= r_ptr + ADDR_WIDTH'(1);
                            r_rd_en <= 1'b1;
                            r_state <= ST_REQ;
                        end
                    end
`ifdef FAULT_MAP_TIMEOUT_EN
                    else if (r_wait_cnt == WAIT_LIMIT) begin
                        // Abort: rows already read stay in the map, map_valid stays low.
                        r_load_err <= 1'b1;
                        r_busy     <= 1'b0;
                        r_state    <= ST_IDLE;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + TW'(1);
                    end
`else
                    else begin
                        r_state <= ST_WAIT;
                    end
`endif
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_rd_en <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    // Per-column fault summary derived directly from the current map.
    always_comb begin
        w_col_any = {S{1'b0}};
        for (int r = 0; r < S; r++) begin
            w_col_any = w_col_any | r_bypass[r*S +: S];
        end
    end

    assign envm_rd_en    = r_rd_en;
    assign envm_rd_addr  = r_ptr;
    assign pe_bypass     = r_bypass;
    assign col_fault_any = w_col_any;
    assign fault_count   = r_count;
    assign busy          = r_busy;
    assign done          = r_done;
    assign map_valid     = r_map_valid;
`ifdef FAULT_MAP_TIMEOUT_EN
    assign load_err      = r_load_err;
`else
    assign load_err      = 1'b0;
`endif

endmodule
